// File: rtl/mul_sweep_pkg.sv
// Shared types and sizing helpers for the multiplier sweep controller.
package mul_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      FINISH = 2'd3
   } sweep_state_t;

   // Number of operand pairs in an exhaustive sweep of a width x width multiplier.
   function automatic int n_vectors(input int width);
      return 1 << (2 * width);
   endfunction

   // Error counter must hold n_vectors itself, hence one bit more than the index.
   function automatic int cnt_width(input int width);
      return 2 * width + 1;
   endfunction

endpackage

// File: rtl/mul_golden_ref.sv
// Golden unsigned multiplier; kept separate so a signed reference can replace it.
module mul_golden_ref #(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [2*WIDTH-1:0] p
);

   assign p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

endmodule

// File: rtl/mul_sweep_ctrl.sv
// Exhaustive sweep of a combinational candidate multiplier against a golden model.
// Optional first-mismatch capture ports: MUL_SWEEP_FAIL_CAPTURE_EN.
module mul_sweep_ctrl
   import mul_sweep_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         abort,
   output logic [WIDTH-1:0]             mul_a,
   output logic [WIDTH-1:0]             mul_b,
   input  logic [2*WIDTH-1:0]           mul_p,
   output logic                         busy,
   output logic                         done,
   output logic [cnt_width(WIDTH)-1:0]  err_count,
   output logic                         pass,
`ifdef MUL_SWEEP_FAIL_CAPTURE_EN
   output logic [WIDTH-1:0]             fail_a,
   output logic [WIDTH-1:0]             fail_b,
   output logic [2*WIDTH-1:0]           fail_p,
   output logic                         fail_valid,
`endif
   output sweep_state_t                 dbg_state
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_width(WIDTH);
   localparam logic [PW-1:0] IDX_LAST = '1;
   localparam logic [CW-1:0] ERR_MAX  = CW'(n_vectors(WIDTH));

   sweep_state_t    state;
   sweep_state_t    state_nxt;
   logic [PW-1:0]   idx;
   logic [PW-1:0]   golden_p;
   logic            mismatch;
   logic            accept;
   logic            sample_go;
   logic [CW-1:0]   err_upd;

   mul_golden_ref #(.WIDTH(WIDTH)) u_golden (
      .a (mul_a),
      .b (mul_b),
      .p (golden_p)
   );

   // Handshake: start is a request accepted only in IDLE (no ready needed, ignored
   // otherwise); done is a single-cycle completion pulse, busy brackets the sweep.
   assign accept    = (state == IDLE) && start;
   assign sample_go = (state == SAMPLE) && !abort;
   assign mismatch  = (mul_p != golden_p);
   assign err_upd   = (mismatch && (err_count != ERR_MAX)) ? err_count + CW'(1) : err_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = DRIVE;
         DRIVE:   state_nxt = abort ? IDLE : SAMPLE;
         SAMPLE: begin
            if (abort)                state_nxt = IDLE;
            else if (idx == IDX_LAST) state_nxt = FINISH;
            else                      state_nxt = DRIVE;
         end
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state != IDLE);
      done      = (state == FINISH);
      dbg_state = state;
   end

   // Pass is resolved on the final SAMPLE edge so it is valid alongside done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         err_count <= '0;
         pass      <= 1'b0;
      end else if (accept) begin
         idx       <= '0;
         err_count <= '0;
         pass      <= 1'b0;
      end else if (state == DRIVE) begin
         mul_a <= idx[WIDTH-1:0];
         mul_b <= idx[PW-1:WIDTH];
      end else if (state == SAMPLE) begin
         if (abort) begin
            pass <= 1'b0;
         end else begin
            err_count <= err_upd;
            if (idx == IDX_LAST) pass <= (err_upd == '0);
            else                 idx  <= idx + PW'(1);
         end
      end
   end

`ifdef MUL_SWEEP_FAIL_CAPTURE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fail_a     <= '0;
         fail_b     <= '0;
         fail_p     <= '0;
         fail_valid <= 1'b0;
      end else if (accept) begin
         fail_a     <= '0;
         fail_b     <= '0;
         fail_p     <= '0;
         fail_valid <= 1'b0;
      end else if (sample_go && mismatch && !fail_valid) begin
         fail_a     <= mul_a;
         fail_b     <= mul_b;
         fail_p     <= mul_p;
         fail_valid <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mul_sweep_ctrl.sv
// Directed bench for mul_sweep_ctrl (WIDTH=2) with a mode-selectable candidate stub.
module tb_mul_sweep_ctrl;
   import mul_sweep_pkg::*;

   localparam int W = 2;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           abort = 1'b0;
   logic [W-1:0]   mul_a;
   logic [W-1:0]   mul_b;
   logic [2*W-1:0] mul_p;
   logic           busy;
   logic           done;
   logic [2*W:0]   err_count;
   logic           pass;
`ifdef MUL_SWEEP_FAIL_CAPTURE_EN
   logic [W-1:0]   fail_a;
   logic [W-1:0]   fail_b;
   logic [2*W-1:0] fail_p;
   logic           fail_valid;
`endif
   sweep_state_t   dbg_state;

   int mode = 0;
   int errors = 0;
   int checks = 0;
   int done_cyc;
   int done_cnt;
   int seen_done;

   mul_sweep_ctrl #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_p      (mul_p),
      .busy       (busy),
      .done       (done),
      .err_count  (err_count),
      .pass       (pass),
`ifdef MUL_SWEEP_FAIL_CAPTURE_EN
      .fail_a     (fail_a),
      .fail_b     (fail_b),
      .fail_p     (fail_p),
      .fail_valid (fail_valid),
`endif
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   // Candidate stub: 0 correct, 1 always zero, 2 product xor 1, 3 wrong only at A=3,B=2
   always_comb begin
      logic [2*W-1:0] prod;
      prod = {2'b00, mul_a} * {2'b00, mul_b};
      case (mode)
         1:       mul_p = '0;
         2:       mul_p = prod ^ 4'd1;
         3:       mul_p = (mul_a == 2'd3 && mul_b == 2'd2) ? 4'd0 : prod;
         default: mul_p = prod;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start, then walk cycles 1..34 recording done; optionally re-pulse start at 5 and 20.
   task automatic run_sweep(input int m, input bit repulse, output int dcyc, output int dcnt);
      mode  = m;
      start = 1'b1;
      step();
      start = 1'b0;
      dcyc = -1;
      dcnt = 0;
      check("busy_after_start", 32'(busy), 32'd1);
      for (int c = 1; c <= 34; c++) begin
         if (done) begin
            dcnt++;
            if (dcyc < 0) dcyc = c;
         end
         if (c == 34) begin
            check("busy_low_c34", 32'(busy), 32'd0);
         end else begin
            start = repulse && (c == 5 || c == 20);
            step();
            start = 1'b0;
         end
      end
   endtask

   initial begin
      // reset state
      repeat (2) step();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err_count), 32'd0);
      check("rst_pass", 32'(pass), 32'd0);
      check("rst_ab", {28'd0, mul_b, mul_a}, 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      step();

      // correct multiplier
      run_sweep(0, 1'b0, done_cyc, done_cnt);
      check("ok_done_cyc", 32'(done_cyc), 32'd33);
      check("ok_done_cnt", 32'(done_cnt), 32'd1);
      check("ok_err", 32'(err_count), 32'd0);
      check("ok_pass", 32'(pass), 32'd1);
      check("ok_hold_ab", {28'd0, mul_b, mul_a}, 32'hF);
`ifdef MUL_SWEEP_FAIL_CAPTURE_EN
      check("ok_fail_valid", 32'(fail_valid), 32'd0);
`endif

      // product stuck at zero
      run_sweep(1, 1'b0, done_cyc, done_cnt);
      check("zero_done_cyc", 32'(done_cyc), 32'd33);
      check("zero_err", 32'(err_count), 32'd9);
      check("zero_pass", 32'(pass), 32'd0);
`ifdef MUL_SWEEP_FAIL_CAPTURE_EN
      check("zero_fail_valid", 32'(fail_valid), 32'd1);
      check("zero_fail_abp", {24'd0, fail_p, fail_b, fail_a}, {24'd0, 4'd0, 2'd1, 2'd1});
`endif

      // product xor 1: every vector wrong
      run_sweep(2, 1'b0, done_cyc, done_cnt);
      check("xor_err", 32'(err_count), 32'd16);
      check("xor_pass", 32'(pass), 32'd0);
`ifdef MUL_SWEEP_FAIL_CAPTURE_EN
      check("xor_fail_abp", {24'd0, fail_p, fail_b, fail_a}, {24'd0, 4'd1, 2'd0, 2'd0});
`endif

      // single bad vector A=3,B=2
      run_sweep(3, 1'b0, done_cyc, done_cnt);
      check("one_err", 32'(err_count), 32'd1);
      check("one_pass", 32'(pass), 32'd0);
`ifdef MUL_SWEEP_FAIL_CAPTURE_EN
      check("one_fail_abp", {24'd0, fail_p, fail_b, fail_a}, {24'd0, 4'd0, 2'd2, 2'd3});
`endif

      // start re-pulsed while busy is ignored
      run_sweep(0, 1'b1, done_cyc, done_cnt);
      check("repulse_done_cyc", 32'(done_cyc), 32'd33);
      check("repulse_done_cnt", 32'(done_cnt), 32'd1);
      check("repulse_pass", 32'(pass), 32'd1);

      // start and abort together in IDLE: start wins; then abort at cycle 10
      mode  = 2;
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      check("startabort_busy", 32'(busy), 32'd1);
      seen_done = 0;
      for (int c = 1; c < 10; c++) begin
         if (done) seen_done++;
         step();
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_busy_c11", 32'(busy), 32'd0);
      check("abort_err_partial", 32'(err_count), 32'd4);
      check("abort_pass", 32'(pass), 32'd0);
      check("abort_hold_ab", {28'd0, mul_b, mul_a}, {28'd0, 2'd1, 2'd0});
      for (int c = 11; c < 40; c++) begin
         if (done) seen_done++;
         step();
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      check("abort_state_idle", 32'(dbg_state), 32'(IDLE));

      // asynchronous reset at cycle 12
      mode  = 2;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c < 12; c++) step();
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_err", 32'(err_count), 32'd0);
      check("midrst_pass", 32'(pass), 32'd0);
      check("midrst_ab", {28'd0, mul_b, mul_a}, 32'd0);
      #2;
      rst = 1'b0;
      step();
      run_sweep(0, 1'b0, done_cyc, done_cnt);
      check("postrst_done_cyc", 32'(done_cyc), 32'd33);
      check("postrst_pass", 32'(pass), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
